// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, default
// widths and the dump/halt encoding of the ex_dmp control bit.
package mem_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned MAX_WAIT_DEF = 15;

  // Value of ex_dmp that marks the dump/halt instruction.
  localparam logic DMP_HALT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  // A store or load needs the data memory; a store wins if both are set.
  function automatic logic is_mem_op(input logic memwrt, input logic memread);
    return memwrt | memread;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a data-memory request waits for its acknowledge.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr_i        synchronous clear (takes priority over enable)
//   en_i         count one waiting cycle
//   expired_c_o  combinational: the enabled increment this cycle reaches MAX_WAIT
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_c_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c_o = en_i && !clr_i && (cnt_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline. Registers each execute-stage
// instruction, runs a req/ack handshake to a variable-latency data memory
// for loads/stores, stalls execute while an access is outstanding, and
// hands a registered result to writeback. Dump/halt and memory timeouts
// park the stage in HALT until reset.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ex_*                          execute-stage payload and controls
//   ex_stall                      combinational back-pressure to execute
//   dm_req/wr/addr/wdata          registered data-memory request
//   dm_ack, dm_rdata              memory completion and read data
//   wb_valid/data/next_pc         registered writeback payload
//   halt, err                     sticky status
// Build option: define MEM_ALIGN_CHECK_EN to trap odd memory addresses
// (no request, err+halt); otherwise addresses pass through unmodified.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_srcb,
  input  logic [DATA_W-1:0] ex_next_pc,
  input  logic              ex_memwrt,
  input  logic              ex_memread,
  input  logic              ex_regsrc,
  input  logic              ex_dmp,
  output logic              ex_stall,
  output logic              dm_req,
  output logic              dm_wr,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] wb_next_pc,
  output logic              halt,
  output logic              err
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] npc_q, npc_d;
  logic              wr_q, wr_d;
  logic              regsrc_q, regsrc_d;
  logic              req_q, req_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] wb_npc_q, wb_npc_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;
  logic              stall_c;
  logic              tmr_clr_c;
  logic              tmr_en_c;
  logic              tmr_expired_c;
  logic              misalign_c;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (tmr_clr_c),
    .en_i        (tmr_en_c),
    .expired_c_o (tmr_expired_c)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_c = ex_alu_out[0];
`else
  assign misalign_c = 1'b0;
`endif

  // Next-state, capture and back-pressure logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    npc_d      = npc_q;
    wr_d       = wr_q;
    regsrc_d   = regsrc_q;
    req_d      = req_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_npc_d   = wb_npc_q;
    halt_d     = halt_q;
    err_d      = err_q;
    stall_c    = 1'b0;
    tmr_clr_c  = 1'b1;
    tmr_en_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (ex_dmp == DMP_HALT) begin
            halt_d  = 1'b1;
            state_d = ST_HALT;
          end else if (is_mem_op(ex_memwrt, ex_memread)) begin
            // Hold execute in the capture cycle so it keeps this instruction.
            stall_c = 1'b1;
            if (misalign_c) begin
              err_d   = 1'b1;
              halt_d  = 1'b1;
              state_d = ST_HALT;
            end else begin
              addr_d   = ex_alu_out;
              wdata_d  = ex_srcb;
              wr_d     = ex_memwrt;
              regsrc_d = ex_regsrc;
              npc_d    = ex_next_pc;
              req_d    = 1'b1;
              state_d  = ST_ACCESS;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = ex_alu_out;
            wb_npc_d   = ex_next_pc;
          end
        end
      end
      ST_ACCESS: begin
        tmr_clr_c = 1'b0;
        if (dm_ack) begin
          // Releasing stall here lets execute advance on this edge.
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = regsrc_q ? dm_rdata : addr_q;
          wb_npc_d   = npc_q;
          state_d    = ST_IDLE;
        end else begin
          stall_c  = 1'b1;
          tmr_en_c = 1'b1;
          if (tmr_expired_c) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            halt_d  = 1'b1;
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        stall_c = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      npc_q      <= '0;
      wr_q       <= 1'b0;
      regsrc_q   <= 1'b0;
      req_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_npc_q   <= '0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      npc_q      <= npc_d;
      wr_q       <= wr_d;
      regsrc_q   <= regsrc_d;
      req_q      <= req_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_npc_q   <= wb_npc_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
    end
  end

  assign ex_stall   = stall_c;
  assign dm_req     = req_q;
  assign dm_wr      = wr_q;
  assign dm_addr    = addr_q;
  assign dm_wdata   = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_next_pc = wb_npc_q;
  assign halt       = halt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load/store handshakes,
// timeout, dump/halt and asynchronous reset during an access.
module tb_mem_stage;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid;
  logic [DW-1:0] ex_alu_out;
  logic [DW-1:0] ex_srcb;
  logic [DW-1:0] ex_next_pc;
  logic          ex_memwrt;
  logic          ex_memread;
  logic          ex_regsrc;
  logic          ex_dmp;
  logic          ex_stall;
  logic          dm_req;
  logic          dm_wr;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] wb_next_pc;
  logic          halt;
  logic          err;

  int errors = 0;
  int checks = 0;

  mem_stage #(.DATA_W(16), .MAX_WAIT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_alu_out (ex_alu_out),
    .ex_srcb    (ex_srcb),
    .ex_next_pc (ex_next_pc),
    .ex_memwrt  (ex_memwrt),
    .ex_memread (ex_memread),
    .ex_regsrc  (ex_regsrc),
    .ex_dmp     (ex_dmp),
    .ex_stall   (ex_stall),
    .dm_req     (dm_req),
    .dm_wr      (dm_wr),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_ack     (dm_ack),
    .dm_rdata   (dm_rdata),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_next_pc (wb_next_pc),
    .halt       (halt),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid   = 1'b0;
    ex_alu_out = '0;
    ex_srcb    = '0;
    ex_next_pc = '0;
    ex_memwrt  = 1'b0;
    ex_memread = 1'b0;
    ex_regsrc  = 1'b0;
    ex_dmp     = 1'b0;
    dm_ack     = 1'b0;
    dm_rdata   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(ex_stall), 32'd0);
    step();
    step();
    rst = 1'b0;

    // ALU op, then a back-to-back ALU op, then a bubble.
    ex_valid = 1'b1; ex_alu_out = 16'h1234; ex_next_pc = 16'h0010;
    #1;
    chk("alu_stall", 32'(ex_stall), 32'd0);
    step();
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_wb_data", 32'(wb_data), 32'h1234);
    chk("alu_wb_npc", 32'(wb_next_pc), 32'h0010);
    ex_alu_out = 16'h0055; ex_next_pc = 16'h0012;
    #1;
    chk("alu2_stall", 32'(ex_stall), 32'd0);
    step();
    chk("alu2_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu2_wb_data", 32'(wb_data), 32'h0055);
    chk("alu2_wb_npc", 32'(wb_next_pc), 32'h0012);
    ex_valid = 1'b0;
    step();
    chk("bubble_wb_valid", 32'(wb_valid), 32'd0);

    // Load from 0x0040, acknowledged in the third request cycle.
    ex_valid = 1'b1; ex_memread = 1'b1; ex_regsrc = 1'b1;
    ex_alu_out = 16'h0040; ex_next_pc = 16'h0020;
    #1;
    chk("ld_stall_c0", 32'(ex_stall), 32'd1);
    step();
    chk("ld_req_a1", 32'(dm_req), 32'd1);
    chk("ld_wr_a1", 32'(dm_wr), 32'd0);
    chk("ld_addr_a1", 32'(dm_addr), 32'h0040);
    chk("ld_stall_a1", 32'(ex_stall), 32'd1);
    chk("ld_wbv_a1", 32'(wb_valid), 32'd0);
    step();
    chk("ld_req_a2", 32'(dm_req), 32'd1);
    chk("ld_stall_a2", 32'(ex_stall), 32'd1);
    step();
    chk("ld_req_a3", 32'(dm_req), 32'd1);
    chk("ld_addr_a3", 32'(dm_addr), 32'h0040);
    dm_ack = 1'b1; dm_rdata = 16'hBEEF;
    #1;
    chk("ld_stall_ack", 32'(ex_stall), 32'd0);
    step();
    idle_inputs();
    chk("ld_wb_valid", 32'(wb_valid), 32'd1);
    chk("ld_wb_data", 32'(wb_data), 32'hBEEF);
    chk("ld_wb_npc", 32'(wb_next_pc), 32'h0020);
    chk("ld_req_done", 32'(dm_req), 32'd0);
    step();
    chk("ld_wb_pulse", 32'(wb_valid), 32'd0);

    // Store with memread also set (store wins), acknowledged at once.
    ex_valid = 1'b1; ex_memwrt = 1'b1; ex_memread = 1'b1; ex_regsrc = 1'b0;
    ex_alu_out = 16'h0042; ex_srcb = 16'h5A5A; ex_next_pc = 16'h0022;
    step();
    chk("st_req", 32'(dm_req), 32'd1);
    chk("st_wr", 32'(dm_wr), 32'd1);
    chk("st_addr", 32'(dm_addr), 32'h0042);
    chk("st_wdata", 32'(dm_wdata), 32'h5A5A);
    dm_ack = 1'b1; dm_rdata = 16'hDEAD;
    step();
    idle_inputs();
    chk("st_wb_valid", 32'(wb_valid), 32'd1);
    chk("st_wb_data", 32'(wb_data), 32'h0042);
    chk("st_req_done", 32'(dm_req), 32'd0);

    // Stray acknowledge while idle has no effect.
    dm_ack = 1'b1; dm_rdata = 16'h1111;
    step();
    dm_ack = 1'b0;
    chk("stray_ack_wbv", 32'(wb_valid), 32'd0);
    chk("stray_ack_req", 32'(dm_req), 32'd0);

    // Odd address: trapped with the alignment check, passed through without.
    ex_valid = 1'b1; ex_memread = 1'b1; ex_regsrc = 1'b1; ex_alu_out = 16'h0041;
    step();
`ifdef MEM_ALIGN_CHECK_EN
    chk("odd_req", 32'(dm_req), 32'd0);
    chk("odd_err", 32'(err), 32'd1);
    chk("odd_halt", 32'(halt), 32'd1);
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
`else
    chk("odd_req", 32'(dm_req), 32'd1);
    chk("odd_addr", 32'(dm_addr), 32'h0041);
    dm_ack = 1'b1; dm_rdata = 16'h0F0F;
    step();
    idle_inputs();
    chk("odd_wb_data", 32'(wb_data), 32'h0F0F);
    chk("odd_err", 32'(err), 32'd0);
`endif

    // Dump/halt, then an ALU op that must never reach writeback.
    step();
    ex_valid = 1'b1; ex_dmp = 1'b1;
    step();
    chk("dmp_halt", 32'(halt), 32'd1);
    chk("dmp_wbv", 32'(wb_valid), 32'd0);
    ex_dmp = 1'b0; ex_alu_out = 16'h7777; ex_next_pc = 16'h0030;
    #1;
    chk("dmp_stall", 32'(ex_stall), 32'd1);
    step();
    chk("dmp_op_wbv", 32'(wb_valid), 32'd0);
    chk("dmp_req", 32'(dm_req), 32'd0);
    chk("dmp_halt_sticky", 32'(halt), 32'd1);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("dmp_rst_halt", 32'(halt), 32'd0);
    #1;
    rst = 1'b0;

    // Load that is never acknowledged: 15 request cycles, then timeout.
    ex_valid = 1'b1; ex_memread = 1'b1; ex_regsrc = 1'b1; ex_alu_out = 16'h0044;
    step();
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("to_req_a%0d", i), 32'(dm_req), 32'd1);
      chk($sformatf("to_err_a%0d", i), 32'(err), 32'd0);
      step();
    end
    chk("to_req", 32'(dm_req), 32'd0);
    chk("to_err", 32'(err), 32'd1);
    chk("to_halt", 32'(halt), 32'd1);
    chk("to_wbv", 32'(wb_valid), 32'd0);
    step();
    chk("to_wbv2", 32'(wb_valid), 32'd0);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("to_rst_err", 32'(err), 32'd0);
    #1;
    rst = 1'b0;

    // Reset in the middle of an access, then an ALU op.
    ex_valid = 1'b1; ex_memread = 1'b1; ex_alu_out = 16'h0046;
    step();
    chk("mid_req_a1", 32'(dm_req), 32'd1);
    step();
    rst = 1'b1;
    ex_memread = 1'b0; ex_alu_out = 16'h0099; ex_next_pc = 16'h0032;
    #1;
    chk("mid_rst_req", 32'(dm_req), 32'd0);
    chk("mid_rst_stall", 32'(ex_stall), 32'd0);
    #1;
    rst = 1'b0;
    step();
    chk("post_rst_wbv", 32'(wb_valid), 32'd1);
    chk("post_rst_data", 32'(wb_data), 32'h0099);
    chk("post_rst_npc", 32'(wb_next_pc), 32'h0032);
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
